// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction memory address and IF/ID register.
// Define FETCH_PERF_EN to add the fetch/stall/redirect perf counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next;
    logic        bubble;
    logic        load;

    assign pc_plus4_f = pc_f + 32'd4;
    assign imem_addr  = pc_f;
    assign bubble     = flush | pc_src;
    assign load       = !bubble && !stall;

    // A redirect beats a stall so the wrong path is never held.
    always_comb begin
        pc_next = pc_plus4_f;
        if (pc_src)
            pc_next = {pc_target[31:2], 2'b00};
        else if (stall)
            pc_next = pc_f;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_f <= RESET_PC;
        else
            pc_f <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'd0;
            pc_plus4_d <= 32'd0;
            valid_d    <= 1'b0;
        end else if (load) begin
            instr_d    <= imem_instr;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'd0;
            perf_stall_cnt    <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (load)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && !pc_src)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (pc_src)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of expected IF/ID state per edge.
// Perf counter test is built only when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
    } exp_t;

    typedef struct packed {
        logic        st;
        logic        fl;
        logic        src;
        logic [31:0] tgt;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'd0;

    logic [31:0] imem_addr, imem_instr, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
    logic [31:0] h_addr, h_instr, h_instr_d, h_pc_d, h_pc4_d;
    logic        h_valid_d;
`ifdef FETCH_PERF_EN
    logic [31:0] pf, ps, pr, hpf, hps, hpr;
`endif

    int errors = 0;
    int checks = 0;
    exp_t  sb[$];
    stim_t stq[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_instr = pat(imem_addr);
    assign h_instr    = pat(h_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .pc_src(pc_src), .pc_target(pc_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(pf), .perf_stall_cnt(ps),
        .perf_redirect_cnt(pr)
`endif
    );

    fetch_stage #(.RESET_PC(32'h100)) dut_hi (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .pc_src(pc_src), .pc_target(pc_target),
        .imem_addr(h_addr), .imem_instr(h_instr),
        .instr_d(h_instr_d), .pc_d(h_pc_d),
        .pc_plus4_d(h_pc4_d), .valid_d(h_valid_d)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(hpf), .perf_stall_cnt(hps),
        .perf_redirect_cnt(hpr)
`endif
    );

    function automatic exp_t ld(input logic [31:0] a);
        return '{pat(a), a, a + 32'd4, 1'b1, a + 32'd4};
    endfunction

    function automatic exp_t bub(input logic [31:0] a);
        return '{NOP, 32'd0, 32'd0, 1'b0, a};
    endfunction

    task automatic add(input logic st, input logic fl,
                       input logic src, input logic [31:0] tgt,
                       input exp_t e);
        stq.push_back('{st, fl, src, tgt});
        sb.push_back(e);
    endtask

    task automatic cyc(input stim_t s);
        stall = s.st; flush = s.fl;
        pc_src = s.src; pc_target = s.tgt;
        @(posedge clk); #1;
        stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o, e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(bub(32'd0));
        o = {instr_d, pc_d, pc_plus4_d, valid_d, imem_addr};
        e = sb.pop_front(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset0: got %h want %h", o, e);
        end
        checks++;
        if ({h_instr_d, h_valid_d, h_addr} !== {NOP, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL reset_hi: got instr=%h v=%b addr=%h want %h 0 100",
                     h_instr_d, h_valid_d, h_addr, NOP);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({h_instr_d, h_pc_d, h_valid_d, h_addr} !==
            {pat(32'h100), 32'h100, 1'b1, 32'h104}) begin
            errors++;
            $display("FAIL reset_first: got instr=%h pc=%h v=%b addr=%h",
                     h_instr_d, h_pc_d, h_valid_d, h_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({h_pc_d, h_pc4_d, h_valid_d} !== {32'h108, 32'h10C, 1'b1}) begin
            errors++;
            $display("FAIL reset_third: got pc=%h pc4=%h v=%b want 108 10c 1",
                     h_pc_d, h_pc4_d, h_valid_d);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({h_instr_d, h_pc_d, h_valid_d, h_addr} !==
            {NOP, 32'd0, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL reset_mid: got instr=%h pc=%h v=%b addr=%h",
                     h_instr_d, h_pc_d, h_valid_d, h_addr);
        end
    endtask

    task automatic test_sequential();
        exp_t o, e;
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 32'd0, ld(32'(4 * i)));
        while (stq.size() > 0) begin
            cyc(stq.pop_front());
            o = {instr_d, pc_d, pc_plus4_d, valid_d, imem_addr};
            e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL seq #%0d: got pc=%h pc4=%h v=%b instr=%h want pc=%h pc4=%h v=%b instr=%h",
                         n, o.pc, o.pc4, o.valid, o.instr, e.pc, e.pc4, e.valid, e.instr);
            end
            n++;
        end
    endtask

    task automatic test_stall();
        exp_t o, e;
        int n = 0;
        do_reset();
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 32'd0, ld(32'(4 * i)));
        repeat (3) add(1, 0, 0, 32'd0, ld(32'h10));
        add(0, 0, 0, 32'd0, ld(32'h14));
        add(0, 0, 0, 32'd0, ld(32'h18));
        while (stq.size() > 0) begin
            cyc(stq.pop_front());
            o = {instr_d, pc_d, pc_plus4_d, valid_d, imem_addr};
            e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall #%0d: got pc=%h v=%b addr=%h instr=%h want pc=%h v=%b addr=%h instr=%h",
                         n, o.pc, o.valid, o.addr, o.instr, e.pc, e.valid, e.addr, e.instr);
            end
            n++;
        end
    endtask

    task automatic test_redirect();
        exp_t o, e;
        int n = 0;
        do_reset();
        add(0, 0, 0, 32'd0, ld(32'h0));
        add(0, 0, 0, 32'd0, ld(32'h4));
        add(1, 0, 1, 32'h40, bub(32'h40));
        add(0, 0, 0, 32'd0, ld(32'h40));
        add(0, 0, 0, 32'd0, ld(32'h44));
        while (stq.size() > 0) begin
            cyc(stq.pop_front());
            o = {instr_d, pc_d, pc_plus4_d, valid_d, imem_addr};
            e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL redirect #%0d: got pc=%h v=%b addr=%h instr=%h want pc=%h v=%b addr=%h instr=%h",
                         n, o.pc, o.valid, o.addr, o.instr, e.pc, e.valid, e.addr, e.instr);
            end
            n++;
        end
    endtask

    task automatic test_flush_align();
        exp_t o, e;
        int n = 0;
        do_reset();
        add(0, 0, 0, 32'd0, ld(32'h0));
        add(0, 0, 0, 32'd0, ld(32'h4));
        add(1, 1, 0, 32'd0, bub(32'h8));
        add(0, 0, 0, 32'd0, ld(32'h8));
        add(0, 0, 1, 32'h43, bub(32'h40));
        add(0, 0, 0, 32'd0, ld(32'h40));
        add(0, 1, 0, 32'd0, bub(32'h48));
        add(0, 0, 0, 32'd0, ld(32'h48));
        while (stq.size() > 0) begin
            cyc(stq.pop_front());
            o = {instr_d, pc_d, pc_plus4_d, valid_d, imem_addr};
            e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flush #%0d: got pc=%h v=%b addr=%h instr=%h want pc=%h v=%b addr=%h instr=%h",
                         n, o.pc, o.valid, o.addr, o.instr, e.pc, e.valid, e.addr, e.instr);
            end
            n++;
        end
    endtask

    task automatic test_wrap();
        exp_t o, e;
        int n = 0;
        add(0, 0, 1, 32'hFFFF_FFFC, bub(32'hFFFF_FFFC));
        add(0, 0, 0, 32'd0, ld(32'hFFFF_FFFC));
        add(0, 0, 0, 32'd0, ld(32'h0));
        while (stq.size() > 0) begin
            cyc(stq.pop_front());
            o = {instr_d, pc_d, pc_plus4_d, valid_d, imem_addr};
            e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap #%0d: got pc=%h pc4=%h addr=%h want pc=%h pc4=%h addr=%h",
                         n, o.pc, o.pc4, o.addr, e.pc, e.pc4, e.addr);
            end
            n++;
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if ({pf, ps, pr} !== 96'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", pf, ps, pr);
        end
        repeat (5) cyc('{1'b0, 1'b0, 1'b0, 32'd0});
        repeat (2) cyc('{1'b1, 1'b0, 1'b0, 32'd0});
        cyc('{1'b1, 1'b0, 1'b1, 32'h80});
        cyc('{1'b0, 1'b1, 1'b0, 32'd0});
        repeat (5) cyc('{1'b0, 1'b0, 1'b0, 32'd0});
        checks++;
        if ({pf, ps, pr} !== {32'd10, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL perf_count: got %0d/%0d/%0d want 10/2/1", pf, ps, pr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush_align();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
